// File: rtl/timer_sample_ctrl.sv
`timescale 1ns/1ps
// timer_sample_ctrl: owns one timer core's enable/clear and shares its single
// sample path among N_REQ requesters via a round-robin arbiter.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   en_set, en_clr, cnt_clr  timer enable set/clear and counter clear pulses
//   req / ack                level requests in, one-hot ack pulses out
//   value, gnt_id, busy      timestamp, granted index, sequencer busy
//   timer_enable, timer_sample, timer_rst, timer_value  core interface
module timer_sample_ctrl #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_set,
    input  logic                en_clr,
    input  logic                cnt_clr,
    input  logic [N_REQ-1:0]    req,
    output logic [N_REQ-1:0]    ack,
    output logic [2*DATA_W-1:0] value,
    output logic [ID_W-1:0]     gnt_id,
    output logic                busy,
    output logic                timer_enable,
    output logic                timer_sample,
    output logic                timer_rst,
    input  logic [2*DATA_W-1:0] timer_value
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t          state;
    logic            clr_pend;
    logic            clr_issue;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] next_ptr;

    // A pending clear is only released while idle, so it never lands
    // between a sample and its capture.
    assign clr_issue = clr_pend && (state == IDLE);
    assign timer_rst = rst || clr_issue;

    assign next_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

    // Round-robin search: start at rr_ptr, ascend with wrap.
    always_comb begin
        logic            found;
        logic [ID_W:0]   pos;
        win   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (pos >= (ID_W + 1)'(N_REQ)) begin
                pos = pos - (ID_W + 1)'(N_REQ);
            end
            if (!found && req[pos[ID_W-1:0]]) begin
                found = 1'b1;
                win   = pos[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ack          <= '0;
            value        <= '0;
            gnt_id       <= '0;
            busy         <= 1'b0;
            timer_enable <= 1'b0;
            timer_sample <= 1'b0;
            clr_pend     <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            if (en_clr) begin
                timer_enable <= 1'b0;
            end else if (en_set) begin
                timer_enable <= 1'b1;
            end

            if (clr_issue) begin
                clr_pend <= 1'b0;
            end
            if (cnt_clr) begin
                clr_pend <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if ((|req) && !clr_issue) begin
                        gnt_id       <= win;
                        timer_sample <= 1'b1;
                        busy         <= 1'b1;
                        state        <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    timer_sample <= 1'b0;
                    state        <= CAPTURE;
                end
                CAPTURE: begin
                    value <= timer_value;
                    ack   <= N_REQ'(1) << gnt_id;
                    state <= ACK;
                end
                ACK: begin
                    ack    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
